centroid_detect: RTL and testbench

CENTROID_DETECT -- requirements
Module: centroid_detect

---
 rtl/centroid_detect_if.sv | 21 ++
 rtl/centroid_detect.sv | 163 ++++++++++++++++
 tb/tb_centroid_detect.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/centroid_detect_if.sv
// Pixel-stream / centroid-result bundle for centroid_detect.
// master drives video timing + binary pixel, slave returns centroid results.
interface centroid_detect_if;
  logic        Binary_in;
  logic [11:0] VtcHCnt;
  logic [10:0] VtcVCnt;
  logic [11:0] center_h;
  logic [10:0] center_v;
  logic        center_valid;
  logic        ball_found;

  modport master (
    output Binary_in, VtcHCnt, VtcVCnt,
    input  center_h, center_v, center_valid, ball_found
  );

  modport slave (
    input  Binary_in, VtcHCnt, VtcVCnt,
    output center_h, center_v, center_valid, ball_found
  );
endinterface

// File: rtl/centroid_detect.sv
// Per-frame centroid of a thresholded ball: accumulate, then serial divide.
// Optional macro CENTROID_SMOOTH_EN averages consecutive found centres.
module centroid_detect #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int MIN_PIXELS = 16
) (
  input logic              PClk,
  input logic              RstN,
  centroid_detect_if.slave pix_if
);
  localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [16:0] MIN_CNT = 17'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIV_H, DIV_V, DONE} state_t;
  state_t state, next_state;

  logic [10:0] prev_v;
  logic [31:0] sum_h, sum_v;
  logic [16:0] count;
  logic [31:0] snap_sum_v;
  logic [16:0] snap_count;
  logic [31:0] div_q;
  logic [16:0] div_rem;
  logic [4:0]  bit_cnt;
  logic [11:0] quot_h;
  logic        pix_hit, eof, found;
  logic [17:0] trial, diff;
  logic        trial_ge;
  logic [16:0] rem_next;
  logic [31:0] q_next;

  assign pix_hit = pix_if.Binary_in && (pix_if.VtcHCnt < H_LIM) && (pix_if.VtcVCnt < V_LIM);
  assign eof     = (prev_v == V_LAST) && (pix_if.VtcVCnt != V_LAST);
  assign found   = (snap_count >= MIN_CNT) && (snap_count != '0);

  // One restoring-division step; div_q shifts dividend out and quotient in.
  assign trial    = {div_rem, div_q[31]};
  assign diff     = trial - {1'b0, snap_count};
  assign trial_ge = trial >= {1'b0, snap_count};
  assign rem_next = trial_ge ? diff[16:0] : trial[16:0];
  assign q_next   = {div_q[30:0], trial_ge};

  // The EOF cycle's own pixel seeds the next frame's accumulators.
  always_ff @(posedge PClk or negedge RstN) begin
    if (!RstN) begin
      prev_v <= '0;
      sum_h  <= '0;
      sum_v  <= '0;
      count  <= '0;
    end else begin
      prev_v <= pix_if.VtcVCnt;
      if (eof) begin
        sum_h <= pix_hit ? {20'd0, pix_if.VtcHCnt} : '0;
        sum_v <= pix_hit ? {21'd0, pix_if.VtcVCnt} : '0;
        count <= pix_hit ? 17'd1 : '0;
      end else if (pix_hit) begin
        sum_h <= sum_h + {20'd0, pix_if.VtcHCnt};
        sum_v <= sum_v + {21'd0, pix_if.VtcVCnt};
        count <= count + 17'd1;
      end
    end
  end

  always_ff @(posedge PClk or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (eof) next_state = DIV_H;
      DIV_H:   if (bit_cnt == 5'd31) next_state = DIV_V;
      DIV_V:   if (bit_cnt == 5'd31) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // EOFs outside IDLE are ignored here, so a running division is never disturbed.
  always_ff @(posedge PClk or negedge RstN) begin
    if (!RstN) begin
      snap_sum_v <= '0;
      snap_count <= '0;
      div_q      <= '0;
      div_rem    <= '0;
      bit_cnt    <= '0;
      quot_h     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eof) begin
            div_q      <= sum_h;
            div_rem    <= '0;
            snap_sum_v <= sum_v;
            snap_count <= count;
            bit_cnt    <= '0;
          end
        end
        DIV_H: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            quot_h  <= q_next[11:0];
            div_q   <= snap_sum_v;
            div_rem <= '0;
          end else begin
            div_q   <= q_next;
            div_rem <= rem_next;
          end
        end
        DIV_V: begin
          bit_cnt <= bit_cnt + 5'd1;
          div_q   <= q_next;
          div_rem <= rem_next;
        end
        default: ;
      endcase
    end
  end

`ifdef CENTROID_SMOOTH_EN
  logic [12:0] avg_h;
  logic [11:0] avg_v;
  assign avg_h = {1'b0, pix_if.center_h} + {1'b0, quot_h} + 13'd1;
  assign avg_v = {1'b0, pix_if.center_v} + {1'b0, div_q[10:0]} + 12'd1;
`endif

  // Results register out of DONE, so center_valid lands the cycle after it.
  always_ff @(posedge PClk or negedge RstN) begin
    if (!RstN) begin
      pix_if.center_h     <= 12'hFFF;
      pix_if.center_v     <= 11'h7FF;
      pix_if.center_valid <= 1'b0;
      pix_if.ball_found   <= 1'b0;
    end else begin
      pix_if.center_valid <= (state == DONE);
      if (state == DONE) begin
        if (found) begin
`ifdef CENTROID_SMOOTH_EN
          if (pix_if.ball_found) begin
            pix_if.center_h <= avg_h[12:1];
            pix_if.center_v <= avg_v[11:1];
          end else begin
            pix_if.center_h <= quot_h;
            pix_if.center_v <= div_q[10:0];
          end
`else
          pix_if.center_h <= quot_h;
          pix_if.center_v <= div_q[10:0];
`endif
          pix_if.ball_found <= 1'b1;
        end else begin
          pix_if.center_h   <= 12'hFFF;
          pix_if.center_v   <= 11'h7FF;
          pix_if.ball_found <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_centroid_detect.sv
// Randomized + directed bench for centroid_detect with a per-frame arithmetic model
// feeding a scoreboard; a negedge monitor pops and compares on center_valid.
module tb_centroid_detect;
  localparam int H   = 320;
  localparam int V   = 240;
  localparam int MIN = 16;
  localparam int LAT = 66;

  typedef struct {
    int unsigned h;
    int unsigned v;
    int unsigned f;
    int unsigned at;
  } exp_t;

  logic PClk = 1'b0;
  logic RstN = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  longint unsigned m_sum_h, m_sum_v, m_cnt;
  int unsigned     m_prev_v, m_busy_until, m_out_h, m_out_v;
  bit              m_prev_found;

  centroid_detect_if pix ();

  centroid_detect #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MIN)) dut (
    .PClk   (PClk),
    .RstN   (RstN),
    .pix_if (pix)
  );

  always #5 PClk = ~PClk;
  always @(posedge PClk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_sum_h = 0; m_sum_v = 0; m_cnt = 0;
    m_prev_v = 0; m_busy_until = 0;
    m_out_h = 12'hFFF; m_out_v = 11'h7FF; m_prev_found = 0;
    sb.delete();
  endtask

  // Expected result of the frame just closed: floor mean of counted coordinates.
  task automatic predictFrame();
    exp_t e;
    bit   found;
    int unsigned qh, qv;
    found = (m_cnt >= MIN) && (m_cnt != 0);
    if (found) begin
      qh = int'((m_sum_h / m_cnt) & 64'hFFF);
      qv = int'((m_sum_v / m_cnt) & 64'h7FF);
`ifdef CENTROID_SMOOTH_EN
      if (m_prev_found) begin
        qh = (m_out_h + qh + 1) / 2;
        qv = (m_out_v + qv + 1) / 2;
      end
`endif
    end else begin
      qh = 12'hFFF;
      qv = 11'h7FF;
    end
    m_out_h = qh; m_out_v = qv; m_prev_found = found;
    e.h = qh; e.v = qv; e.f = found ? 1 : 0; e.at = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int h, input int v, input bit b);
    bit hit, eof;
    @(posedge PClk); #1;
    pix.Binary_in = b;
    pix.VtcHCnt   = 12'(h);
    pix.VtcVCnt   = 11'(v);
    if (RstN) begin
      hit = b && (h < H) && (v < V);
      eof = (m_prev_v == V - 1) && (v != V - 1);
      if (eof) begin
        if (cyc >= m_busy_until) begin
          predictFrame();
          m_busy_until = cyc + LAT;
        end
        m_sum_h = 0; m_sum_v = 0; m_cnt = 0;
      end
      if (hit) begin
        m_sum_h += h; m_sum_v += v; m_cnt++;
      end
      m_prev_v = v;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus($urandom_range(330, 420), 245, 1'($urandom));
  endtask

  task automatic endFrame(input int h, input int v, input bit b);
    applyStimulus(0, V - 1, 1'b0);
    applyStimulus(h, v, b);
  endtask

  task automatic block(input int h0, input int v0, input int w, input int ht, input int skip);
    for (int y = 0; y < ht; y++)
      for (int x = 0; x < w; x++)
        applyStimulus(h0 + x, v0 + y, (y * w + x) != skip);
  endtask

  task automatic pulseReset(input int cycles);
    @(posedge PClk); #1;
    RstN = 1'b0;
    modelReset();
    repeat (cycles) @(negedge PClk);
    checkOutput("rst_center_h", pix.center_h, 12'hFFF);
    checkOutput("rst_center_v", pix.center_v, 11'h7FF);
    checkOutput("rst_center_valid", pix.center_valid, 0);
    checkOutput("rst_ball_found", pix.ball_found, 0);
    @(posedge PClk); #1;
    RstN = 1'b1;
  endtask

  always @(negedge PClk) begin : monitor
    exp_t e;
    if (RstN) begin
      if (pix.center_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_center_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency_cycle", cyc, e.at);
          checkOutput("center_h", pix.center_h, e.h);
          checkOutput("center_v", pix.center_v, e.v);
          checkOutput("ball_found", pix.ball_found, e.f);
        end
      end else if (sb.size() != 0 && cyc > sb[0].at) begin
        e = sb.pop_front();
        checkOutput("missing_center_valid", 0, 1);
      end
    end
  end

  initial begin
    int n;
    pix.Binary_in = 1'b0;
    pix.VtcHCnt   = '0;
    pix.VtcVCnt   = '0;
    modelReset();
    pulseReset(3);

    // 4x4 block -> (101,51) found; then the same block minus one pixel
    block(100, 50, 4, 4, -1);
    endFrame(0, V, 1'b0);
    idleCycles(70);
    block(100, 50, 4, 4, 15);
    endFrame(0, V, 1'b0);
    idleCycles(70);

    // Ones only in horizontal blanking
    for (int y = 10; y < 13; y++)
      for (int x = 320; x <= 400; x++) applyStimulus(x, y, 1'b1);
    endFrame(0, V, 1'b0);
    idleCycles(70);

    // Dense block touching the right/bottom active edges, plus one blanking column
    block(280, 200, 41, 40, -1);
    endFrame(0, V, 1'b0);
    idleCycles(70);

    // Reset during DIV_H, then a clean frame
    block(100, 50, 4, 4, -1);
    endFrame(0, V, 1'b0);
    idleCycles(10);
    pulseReset(2);
    idleCycles(5);
    block(100, 50, 4, 4, -1);
    endFrame(0, V, 1'b0);
    idleCycles(70);

    // Empty frame, then centres (100,50) and (120,70)
    endFrame(0, V, 1'b0);
    idleCycles(70);
    block(98, 48, 5, 5, -1);
    endFrame(0, V, 1'b0);
    idleCycles(70);
    block(118, 68, 5, 5, -1);
    endFrame(0, V, 1'b0);
    idleCycles(70);

    // Random frames: stray EOFs, carried EOF pixels, and short gaps that drop EOFs
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(0, 60);
      for (int i = 0; i < n; i++)
        applyStimulus($urandom_range(0, 330), $urandom_range(0, 241), $urandom_range(0, 3) != 0);
      endFrame($urandom_range(0, 330), $urandom_range(0, 3) == 0 ? V + 1 : $urandom_range(0, V - 2),
               1'($urandom));
      idleCycles($urandom_range(0, 90));
    end

    idleCycles(5);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge PClk);
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
